// File: rtl/count_seq_pkg.sv
// Shared definitions for the counter sequencer: state encoding and default widths.
package count_seq_pkg;

  localparam int unsigned CNT_W_DEF = 3;

  // Encoding is visible on LEDG, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_HOLD = 2'b11
  } state_t;

endpackage

// File: rtl/count_seq_ctrl_if.sv
// Counter datapath bus between the sequencer (master) and the loadable counter (slave).
//   cnt_q       counter output, driven by the counter
//   cnt_d       parallel-load data, driven by the sequencer
//   cnt_load_n  active-low load strobe, driven by the sequencer
//   cnt_step    count-enable strobe, driven by the sequencer
interface count_seq_ctrl_if #(
  parameter int unsigned CNT_W = count_seq_pkg::CNT_W_DEF
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cnt_load_n;
  logic             cnt_step;

  modport master (input cnt_q, output cnt_d, output cnt_load_n, output cnt_step);
  modport slave  (output cnt_q, input cnt_d, input cnt_load_n, input cnt_step);

endinterface

// File: rtl/key_edge.sv
// Raw active-low push-button to single-cycle press pulse.
// Synchronizer (reset to released), optional debounce filter, falling-edge detect.
// Optional feature macro: COUNT_SEQ_DEBOUNCE_EN (filter enabled when defined).
//   clk, rst  clock, async active-high reset
//   key_n     raw button, active-low
//   pulse     registered 1-cycle pulse per press
module key_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl;
  logic                   lvl_prev_q;

  // Metastability synchronizer; reset to the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
  end

`ifdef COUNT_SEQ_DEBOUNCE_EN
  localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [DB_W-1:0] db_cnt_q;
  logic            flt_q;

  // Filtered level follows the synchronized level only after DB_CYCLES stable cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q <= '0;
      flt_q    <= 1'b1;
    end else if (sync_q[SYNC_STAGES-1] == flt_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
      db_cnt_q <= '0;
      flt_q    <= sync_q[SYNC_STAGES-1];
    end else begin
      db_cnt_q <= db_cnt_q + DB_W'(1);
    end
  end

  assign lvl = flt_q;
`else
  logic unused_db_cycles;
  assign unused_db_cycles = (DB_CYCLES != 0);
  assign lvl = sync_q[SYNC_STAGES-1];
`endif

  // Falling edge of the clean level gives exactly one pulse per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_prev_q <= 1'b1;
      pulse      <= 1'b0;
    end else begin
      lvl_prev_q <= lvl;
      pulse      <= lvl_prev_q & ~lvl;
    end
  end

endmodule

// File: rtl/count_seq_ctrl.sv
// Sequencer for the 3-bit loadable counter: button commands, load/step strobes at a
// programmable tick rate, stop at a switch-selected terminal value.
// Optional feature macro: COUNT_SEQ_DEBOUNCE_EN (button debounce in key_edge).
//   clk, rst              clock, async active-high reset
//   key_start_n           raw start/pause button, active-low
//   key_load_n            raw load button, active-low
//   sw_preset, sw_stop    preset value / terminal count
//   cnt_bus               counter bus (cnt_q in; cnt_d, cnt_load_n, cnt_step out)
//   state, running, done  FSM state, RUN indicator, sticky terminal flag
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start_n,
  input  logic             key_load_n,
  input  logic [CNT_W-1:0] sw_preset,
  input  logic [CNT_W-1:0] sw_stop,
  count_seq_ctrl_if.master cnt_bus,
  output logic [1:0]       state,
  output logic             running,
  output logic             done
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic             start_p;
  logic             load_p;
  state_t           state_q, state_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [CNT_W-1:0] cnt_d_q, cnt_d_n;
  logic             load_n_q, load_n_n;
  logic             step_q, step_n;
  logic             running_q, running_n;
  logic             done_q, done_n;
  logic             tick;
  logic             at_stop;

  key_edge #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_start_edge (
    .clk(clk), .rst(rst), .key_n(key_start_n), .pulse(start_p)
  );

  key_edge #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_load_edge (
    .clk(clk), .rst(rst), .key_n(key_load_n), .pulse(load_p)
  );

  assign tick    = (div_q == DIV_W'(TICK_DIV - 1));
  assign at_stop = (cnt_bus.cnt_q == sw_stop);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  // Next state; load beats start everywhere, pause beats a coincident tick.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_p)       state_n = ST_LOAD;
        else if (start_p) state_n = ST_RUN;
      end
      ST_LOAD: state_n = ST_IDLE;
      ST_RUN: begin
        if (load_p)               state_n = ST_LOAD;
        else if (start_p)         state_n = ST_HOLD;
        else if (tick && at_stop) state_n = ST_HOLD;
      end
      ST_HOLD: begin
        if (load_p)       state_n = ST_LOAD;
        else if (start_p) state_n = ST_RUN;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and the tick divider.
  always_comb begin
    cnt_d_n   = cnt_d_q;
    load_n_n  = 1'b1;
    step_n    = 1'b0;
    running_n = (state_n == ST_RUN);
    done_n    = done_q;
    div_n     = div_q;

    if (state_n == ST_LOAD) begin
      load_n_n = 1'b0;
      done_n   = 1'b0;
      cnt_d_n  = sw_preset;
    end

    if ((state_q == ST_RUN) && tick && !load_p && !start_p) begin
      if (at_stop) done_n = 1'b1;
      else         step_n = 1'b1;
    end

    // Divider runs only while staying in RUN; entering RUN restarts the period.
    if (state_n == ST_RUN) begin
      if (state_q != ST_RUN) div_n = '0;
      else if (tick)         div_n = '0;
      else                   div_n = div_q + DIV_W'(1);
    end
  end

  // Output and divider registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_d_q   <= '0;
      load_n_q  <= 1'b1;
      step_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      div_q     <= '0;
    end else begin
      cnt_d_q   <= cnt_d_n;
      load_n_q  <= load_n_n;
      step_q    <= step_n;
      running_q <= running_n;
      done_q    <= done_n;
      div_q     <= div_n;
    end
  end

  assign cnt_bus.cnt_d      = cnt_d_q;
  assign cnt_bus.cnt_load_n = load_n_q;
  assign cnt_bus.cnt_step   = step_q;
  assign state              = state_q;
  assign running            = running_q;
  assign done               = done_q;

endmodule
